// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline status in, stall/flush/forward controls out
interface pipeline_hazard_ctrl_if;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR;
  logic        ID_USES_RS1, ID_USES_RS2;
  logic [4:0]  EX_RD_ADDR;
  logic        EX_REG_WRITE, EX_MEM_READ;
  logic [4:0]  MEM_RD_ADDR;
  logic        MEM_REG_WRITE;
  logic [4:0]  WB_RD_ADDR;
  logic        WB_REG_WRITE;
  logic [1:0]  MEM_PC_SOURCE;
  logic        MEM_BUSY;
  logic        PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, MEMWB_STALL;
  logic        IDEX_BUBBLE, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, PC_REDIRECT;
  logic [1:0]  FWD_SEL_A, FWD_SEL_B;
  logic [31:0] STALL_CNT, FLUSH_CNT;
  logic        MEM_TIMEOUT;
  modport master (
    input  ID_RS1_ADDR, ID_RS2_ADDR, ID_USES_RS1, ID_USES_RS2, EX_RD_ADDR, EX_REG_WRITE, EX_MEM_READ,
           MEM_RD_ADDR, MEM_REG_WRITE, WB_RD_ADDR, WB_REG_WRITE, MEM_PC_SOURCE, MEM_BUSY,
    output PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, MEMWB_STALL, IDEX_BUBBLE, IFID_FLUSH,
           IDEX_FLUSH, EXMEM_FLUSH, PC_REDIRECT, FWD_SEL_A, FWD_SEL_B, STALL_CNT, FLUSH_CNT, MEM_TIMEOUT
  );
  modport slave (
    output ID_RS1_ADDR, ID_RS2_ADDR, ID_USES_RS1, ID_USES_RS2, EX_RD_ADDR, EX_REG_WRITE, EX_MEM_READ,
           MEM_RD_ADDR, MEM_REG_WRITE, WB_RD_ADDR, WB_REG_WRITE, MEM_PC_SOURCE, MEM_BUSY,
    input  PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, MEMWB_STALL, IDEX_BUBBLE, IFID_FLUSH,
           IDEX_FLUSH, EXMEM_FLUSH, PC_REDIRECT, FWD_SEL_A, FWD_SEL_B, STALL_CNT, FLUSH_CNT, MEM_TIMEOUT
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/bubble/flush sequencing, forwarding selects and perf counters for the Otter pipeline
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic CLK,
  input logic RST,
  pipeline_hazard_ctrl_if.master bus
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIR_PEND} state_t;
  state_t state, state_nxt;
  logic [4:0]  ex_rs1, ex_rs2;
  logic [15:0] busy_cnt;
  logic [31:0] stall_cnt, flush_cnt;
  logic        timeout, load_use, freeze, lu_stall, redir;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (bus.MEM_REG_WRITE && bus.MEM_RD_ADDR != 5'd0 && bus.MEM_RD_ADDR == rs) ? 2'b01 :
           (bus.WB_REG_WRITE && bus.WB_RD_ADDR != 5'd0 && bus.WB_RD_ADDR == rs) ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    redir     = 1'b0;
    lu_stall  = 1'b0;
    load_use  = bus.EX_MEM_READ && bus.EX_REG_WRITE && bus.EX_RD_ADDR != 5'd0 &&
                ((bus.ID_USES_RS1 && bus.ID_RS1_ADDR == bus.EX_RD_ADDR) ||
                 (bus.ID_USES_RS2 && bus.ID_RS2_ADDR == bus.EX_RD_ADDR));
    if (!RST)
      case (state)
        RUN: begin
          freeze    = bus.MEM_BUSY;
          state_nxt = !bus.MEM_BUSY ? RUN : (|bus.MEM_PC_SOURCE) ? REDIR_PEND : MEM_WAIT;
          redir     = !bus.MEM_BUSY && |bus.MEM_PC_SOURCE;
          lu_stall  = !bus.MEM_BUSY && !(|bus.MEM_PC_SOURCE) && load_use;
        end
        MEM_WAIT: begin
          freeze    = bus.MEM_BUSY;
          state_nxt = bus.MEM_BUSY ? MEM_WAIT : RUN;
        end
        REDIR_PEND: begin
          freeze    = bus.MEM_BUSY;
          redir     = !bus.MEM_BUSY;
          state_nxt = bus.MEM_BUSY ? REDIR_PEND : RUN;
        end
        default: state_nxt = RUN;
      endcase
  end
  assign bus.PC_STALL    = freeze || lu_stall;
  assign bus.IFID_STALL  = freeze || lu_stall;
  assign bus.IDEX_STALL  = freeze;
  assign bus.EXMEM_STALL = freeze;
  assign bus.MEMWB_STALL = freeze;
  assign bus.IDEX_BUBBLE = lu_stall;
  assign bus.IFID_FLUSH  = redir;
  assign bus.IDEX_FLUSH  = redir;
  assign bus.EXMEM_FLUSH = redir;
  assign bus.PC_REDIRECT = redir;
  assign bus.FWD_SEL_A   = fwd(ex_rs1);
  assign bus.FWD_SEL_B   = fwd(ex_rs2);
  assign bus.STALL_CNT   = stall_cnt;
  assign bus.FLUSH_CNT   = flush_cnt;
  assign bus.MEM_TIMEOUT = timeout;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      ex_rs1    <= 5'd0;
      ex_rs2    <= 5'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
      busy_cnt  <= 16'd0;
      timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      // a NOP entering ID/EX carries no sources, so nothing may forward to it
      if (lu_stall || redir) begin
        ex_rs1 <= 5'd0;
        ex_rs2 <= 5'd0;
      end else if (!freeze) begin
        ex_rs1 <= bus.ID_RS1_ADDR;
        ex_rs2 <= bus.ID_RS2_ADDR;
      end
      stall_cnt <= stall_cnt + {31'd0, bus.PC_STALL && !(&stall_cnt)};
      flush_cnt <= flush_cnt + {31'd0, redir && !(&flush_cnt)};
      busy_cnt  <= bus.MEM_BUSY ? busy_cnt + {15'd0, !(&busy_cnt)} : 16'd0;
      if (bus.MEM_BUSY && 32'(busy_cnt) + 32'd1 >= TIMEOUT) timeout <= 1'b1;
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage Otter pipeline (IF, ID, EX, MEM, WB). Each cycle it generates stall, bubble and flush controls for the pipeline registers. It also generates operand-forwarding selects for the execute stage's ALU and branch inputs. It tracks data-memory wait states, handles taken control transfers reported one cycle after EX, and keeps stall/flush performance counters.

## Interface
- `TIMEOUT`, default 255: number of consecutive `MEM_BUSY` cycles after which `MEM_TIMEOUT` sets.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  synchronous, active-high reset.
- `ID_RS1_ADDR`, `ID_RS2_ADDR`  in  5 each  source registers of the instruction in ID.
- `ID_USES_RS1`, `ID_USES_RS2`  in  1 each  ID instruction reads that source.
- `EX_RD_ADDR`  in  5  destination register of the instruction in EX.
- `EX_REG_WRITE`  in  1  EX instruction writes a register.
- `EX_MEM_READ`  in  1  EX instruction is a load.
- `MEM_RD_ADDR`, `MEM_REG_WRITE`  in  5/1  destination information for the instruction in MEM.
- `WB_RD_ADDR`, `WB_REG_WRITE`  in  5/1  destination information for the instruction in WB.
- `MEM_PC_SOURCE`  in  2  registered `PC_SOURCE` from the execute stage; nonzero means a taken redirect.
- `MEM_BUSY`  in  1  data memory not ready; MEM cannot complete.
- `PC_STALL`, `IFID_STALL`, `IDEX_STALL`, `EXMEM_STALL`, `MEMWB_STALL`  out  1 each  hold the corresponding register.
- `IDEX_BUBBLE`  out  1  load a NOP into ID/EX.
- `IFID_FLUSH`, `IDEX_FLUSH`, `EXMEM_FLUSH`  out  1 each  load a NOP into the corresponding register.
- `PC_REDIRECT`  out  1  PC takes the target selected by `MEM_PC_SOURCE`.
- `FWD_SEL_A`, `FWD_SEL_B`  out  2 each  `00` selects the register file, `01` the MEM-stage ALU result, `10` the WB write data.
- `STALL_CNT`, `FLUSH_CNT`  out  32 each  performance counters.
- `MEM_TIMEOUT`  out  1  sticky error flag.

## Operation
- FSM states: `RUN`, `MEM_WAIT`, `REDIR_PEND`. Reset state is `RUN`.
- **Forwarding** (combinational, evaluated in every state):
  - `FWD_SEL_A` = `01` if `MEM_REG_WRITE` and `MEM_RD_ADDR` is nonzero and equals the EX rs1.
  - Otherwise `10` under the same test on WB.
  - Otherwise `00`.
  - `FWD_SEL_B` uses the same rules for rs2.
  - MEM has priority over WB. x0 is never forwarded.
  - The EX rs1/rs2 come from an internal copy of `ID_RS*_ADDR`, registered when ID/EX advances. The copy is cleared to 0 on bubble or flush.
- **Load-use** (`RUN` only):
  - Condition: `EX_MEM_READ`, `EX_REG_WRITE`, `EX_RD_ADDR` nonzero, and it matches a used ID source.
  - Response: assert `PC_STALL`, `IFID_STALL` and `IDEX_BUBBLE` for exactly one cycle.
  - On the next cycle the load is in MEM and the consumer is still in ID with no repeat hazard. The load result is later forwarded from WB.
- **Redirect** (`RUN`): when `MEM_PC_SOURCE` is nonzero and `MEM_BUSY` is low, assert `PC_REDIRECT`, `IFID_FLUSH`, `IDEX_FLUSH` and `EXMEM_FLUSH` in the same cycle. Redirect overrides a load-use stall in that cycle.
- **Memory wait**:
  - `MEM_BUSY` high in `RUN`:
    - Assert all `*_STALL` outputs and move to `MEM_WAIT`.
    - If `MEM_PC_SOURCE` is nonzero, latch the redirect and move to `REDIR_PEND` instead.
  - In `MEM_WAIT` or `REDIR_PEND`, all stalls stay asserted while `MEM_BUSY` is high.
  - When `MEM_BUSY` falls:
    - From `MEM_WAIT`: return to `RUN` and deassert all stalls that cycle.
    - From `REDIR_PEND`: assert the redirect flush set that cycle, then return to `RUN`.
  - No bubble or flush is issued while frozen.
- **Counters** (saturate at 2^32-1):
  - `STALL_CNT` increments in any cycle with `PC_STALL` high.
  - `FLUSH_CNT` increments in any cycle with `PC_REDIRECT` high.
- **Timeout**:
  - An internal 16-bit counter counts consecutive busy cycles and clears when `MEM_BUSY` is low.
  - When the count reaches `TIMEOUT`, `MEM_TIMEOUT` sets. It clears only on `RST`.
  - Stalls continue after the timeout.

## Timing
- Reset: FSM to `RUN`, both counters 0, `MEM_TIMEOUT` 0, internal EX source copies 0.
  - Combinational outputs with all-zero inputs: all stall/bubble/flush/redirect outputs 0, `FWD_SEL_A`/`FWD_SEL_B` `00`.
- Reset mid-`MEM_WAIT` or mid-`REDIR_PEND` discards any pending redirect.
- Control outputs are combinational from the state and current inputs, so there is zero-cycle latency to the pipeline registers.
- State, counters and flag update on the rising edge of `CLK`.
- Counter values are visible the cycle after the qualifying event.
- Priority, highest first: `RST`, `MEM_BUSY` freeze, redirect, load-use.

## Test plan
- Load x5 in EX, `add` using x5 in ID -> one cycle with `PC_STALL`=`IFID_STALL`=`IDEX_BUBBLE`=1, next cycle all 0; `STALL_CNT`=1.
- `add` x3 in MEM, `sub` reading x3/x3 in EX, WB also writes x3 -> `FWD_SEL_A`=`FWD_SEL_B`=`01`. With x0 as the destination -> `00`.
- `MEM_PC_SOURCE`=2 with load-use also present -> redirect plus the three flushes, no `IDEX_BUBBLE`; `FLUSH_CNT`=1.
- `MEM_BUSY` high 3 cycles with `MEM_PC_SOURCE`=3 -> all stalls for 3 cycles, no flush, then redirect and flushes on the release cycle; `STALL_CNT`=3.
- `TIMEOUT`=4, `MEM_BUSY` held 6 cycles -> `MEM_TIMEOUT` rises after the 4th busy cycle and remains 1 after release until `RST`.
- `RST` asserted during `REDIR_PEND` -> no redirect after `MEM_BUSY` drops, counters 0.
